io_pinmux: RTL and testbench

//  Run-time programmable pad multiplexer between the N5 SoC peripherals and the Caravel user IO pads.
//  - Each pad selects one of NFUNC peripheral functions through a per-pad select register.
//  - Pad inputs pass through synchronisers.
//  - Function changes are glitch-guarded: the pad is forced to input for GUARD_CYC cycles before the new function drives it.

---
 rtl/io_pinmux.sv | 192 +++++++++++++++++++
 tb/tb_io_pinmux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_pinmux.sv
// io_pinmux -- run-time programmable pad multiplexer.
//
// Each pad picks one of NFUNC peripheral functions through a per-pad select
// register (fsel). Changing a select opens a guard window of GUARD_CYC
// cycles. During the window the pad is held as an input driving 0, and the
// peripheral inputs read idle. This stops a half-switched function from
// glitching the pad or the peripheral.
//
// Optional feature macro: PINMUX_LOCK_EN
//   When defined, address NPADS is a sticky LOCK bit. Once it is set, all
//   later fsel writes are refused until HRESETn.
//
// Ports:
//   HCLK, HRESETn      clock, synchronous active-low reset
//   reg_sel/we/addr/wdata  register request (one per cycle)
//   reg_rdata/ack/err  response, one cycle after the request
//   pad_in/out/oeb     pad side (oeb active-low)
//   fn_out/fn_oeb      peripheral drive, index p*NFUNC+f
//   fn_in              synchronised pad input per peripheral function

module io_pinmux_pad #(
    parameter int   NFUNC       = 4,
    parameter int   FSEL_W      = 2,
    parameter int   GW          = 3,
    parameter int   SYNC_STAGES = 2,
    parameter int   GUARD_CYC   = 4,
    parameter logic IN_IDLE     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [FSEL_W-1:0] wr_val,
    input  logic              pad_in,
    input  logic [NFUNC-1:0]  fn_out,
    input  logic [NFUNC-1:0]  fn_oeb,
    output logic [FSEL_W-1:0] fsel,
    output logic              pad_out,
    output logic              pad_oeb,
    output logic [NFUNC-1:0]  fn_in
);
    logic [GW-1:0] guard;
    logic          s;
    logic          active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsel  <= '0;
            guard <= '0;
        end else if (wr_en) begin
            fsel  <= wr_val;
            guard <= GW'(GUARD_CYC);
        end else if (guard != '0) begin
            guard <= guard - GW'(1);
        end
    end

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = pad_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;
            if (SYNC_STAGES == 1) begin : g_one
                always_ff @(posedge clk) begin
                    if (!rst_n) sync <= IN_IDLE;
                    else        sync <= pad_in;
                end
            end else begin : g_many
                always_ff @(posedge clk) begin
                    if (!rst_n) sync <= {SYNC_STAGES{IN_IDLE}};
                    else        sync <= {sync[SYNC_STAGES-2:0], pad_in};
                end
            end
            assign s = sync[SYNC_STAGES-1];
        end
    endgenerate

    // Reset forces the pad to a safe input combinationally, before any edge.
    assign active  = rst_n && (guard == '0);
    assign pad_out = active ? fn_out[fsel] : 1'b0;
    assign pad_oeb = active ? fn_oeb[fsel] : 1'b1;

    generate
        for (genvar f = 0; f < NFUNC; f++) begin : g_fn
            assign fn_in[f] = ((guard == '0) && (fsel == FSEL_W'(f))) ? s : IN_IDLE;
        end
    endgenerate
endmodule

module io_pinmux #(
    parameter int   NPADS       = 38,
    parameter int   NFUNC       = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   GUARD_CYC   = 4,
    parameter logic IN_IDLE     = 1'b1,
    parameter int   ADDR_W      = 6
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   reg_sel,
    input  logic                   reg_we,
    input  logic [ADDR_W-1:0]      reg_addr,
    input  logic [31:0]            reg_wdata,
    output logic [31:0]            reg_rdata,
    output logic                   reg_ack,
    output logic                   reg_err,
    input  logic [NPADS-1:0]       pad_in,
    output logic [NPADS-1:0]       pad_out,
    output logic [NPADS-1:0]       pad_oeb,
    input  logic [NPADS*NFUNC-1:0] fn_out,
    input  logic [NPADS*NFUNC-1:0] fn_oeb,
    output logic [NPADS*NFUNC-1:0] fn_in
);
    localparam int FSEL_W = (NFUNC > 1) ? $clog2(NFUNC) : 1;
    localparam int GW     = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

    logic [NPADS-1:0][FSEL_W-1:0] fsel;
    logic [FSEL_W-1:0]            cur_fsel;
    logic [NPADS-1:0]             wr_en;
    logic                         in_range, val_ok, fsel_wr, locked, is_lock;

    // Mux the addressed select without indexing past NPADS.
    always_comb begin
        cur_fsel = '0;
        for (int p = 0; p < NPADS; p++)
            if (32'(reg_addr) == p) cur_fsel = fsel[p];
    end

    assign in_range = 32'(reg_addr) < 32'(NPADS);
    assign val_ok   = reg_wdata < 32'(NFUNC);
    // Rewriting the current value must not restart the guard.
    assign fsel_wr  = reg_sel && reg_we && in_range && val_ok && !locked &&
                      (reg_wdata[FSEL_W-1:0] != cur_fsel);

`ifdef PINMUX_LOCK_EN
    logic lock_q;
    assign is_lock = 32'(reg_addr) == 32'(NPADS);
    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            lock_q <= 1'b0;
        else if (reg_sel && reg_we && is_lock && reg_wdata[0])
            lock_q <= 1'b1;
    end
    assign locked = lock_q;
`else
    assign is_lock = 1'b0;
    assign locked  = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            reg_ack   <= 1'b0;
            reg_err   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ack   <= reg_sel;
            reg_err   <= 1'b0;
            reg_rdata <= '0;
            if (reg_sel) begin
                if (in_range) begin
                    if (!reg_we) reg_rdata <= 32'(cur_fsel);
                    else         reg_err   <= !val_ok || locked;
                end else if (is_lock) begin
                    if (!reg_we) reg_rdata <= {31'b0, locked};
                end else begin
                    reg_err <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NPADS; p++) begin : g_pad
            assign wr_en[p] = fsel_wr && (32'(reg_addr) == p);
            io_pinmux_pad #(
                .NFUNC(NFUNC), .FSEL_W(FSEL_W), .GW(GW),
                .SYNC_STAGES(SYNC_STAGES), .GUARD_CYC(GUARD_CYC), .IN_IDLE(IN_IDLE)
            ) u_pad (
                .clk     (HCLK),
                .rst_n   (HRESETn),
                .wr_en   (wr_en[p]),
                .wr_val  (reg_wdata[FSEL_W-1:0]),
                .pad_in  (pad_in[p]),
                .fn_out  (fn_out[p*NFUNC +: NFUNC]),
                .fn_oeb  (fn_oeb[p*NFUNC +: NFUNC]),
                .fsel    (fsel[p]),
                .pad_out (pad_out[p]),
                .pad_oeb (pad_oeb[p]),
                .fn_in   (fn_in[p*NFUNC +: NFUNC])
            );
        end
    endgenerate
endmodule

// File: tb/tb_io_pinmux.sv
// Bench for io_pinmux: a cycle-count model of fsel/guard/synchroniser is
// compared against the pad and register outputs on every falling edge, and
// directed scenarios add hand-computed literal expectations.
module tb_io_pinmux;
    localparam int NPADS = 38, NFUNC = 4, GUARD = 4, ADDR_W = 6, NF = NPADS * NFUNC;
    localparam bit IDLE = 1'b1;

    logic              HCLK = 0, HRESETn = 0;
    logic              reg_sel = 0, reg_we = 0;
    logic [ADDR_W-1:0] reg_addr = '0;
    logic [31:0]       reg_wdata = '0, reg_rdata;
    logic              reg_ack, reg_err;
    logic [NPADS-1:0]  pad_in = '0, pad_out, pad_oeb;
    logic [NF-1:0]     fn_out = '0, fn_oeb = '0, fn_in;

    io_pinmux #(.NPADS(NPADS), .NFUNC(NFUNC), .SYNC_STAGES(2), .GUARD_CYC(GUARD),
                .IN_IDLE(IDLE), .ADDR_W(ADDR_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .reg_sel(reg_sel), .reg_we(reg_we),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_ack(reg_ack), .reg_err(reg_err), .pad_in(pad_in), .pad_out(pad_out),
        .pad_oeb(pad_oeb), .fn_out(fn_out), .fn_oeb(fn_oeb), .fn_in(fn_in));

    always #5 HCLK = ~HCLK;

    int n_cmp = 0, n_fail = 0;
    bit chk_en = 0, rnd_en = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- model: cycle stamps, not counters ----------------
    int          cyc = 0;
    int          wr_cyc[NPADS];
    int          fsel_m[NPADS];
    bit          lock_m;
    bit [NPADS-1:0] h0, h1;       // pad_in seen at the last and previous edge
    bit          e_ack, e_err;
    logic [31:0] e_rdata;

    always @(posedge HCLK) begin
        int a;
        cyc++;
        if (!HRESETn) begin
            for (int p = 0; p < NPADS; p++) begin fsel_m[p] = 0; wr_cyc[p] = -100; end
            lock_m = 0; h0 = '1; h1 = '1; e_ack = 0; e_err = 0; e_rdata = 0;
        end else begin
            h1 = h0; h0 = pad_in;
            e_ack = reg_sel; e_err = 0; e_rdata = 0;
            if (reg_sel) begin
                a = int'(reg_addr);
                if (a < NPADS) begin
                    if (!reg_we) e_rdata = fsel_m[a];
                    else if (reg_wdata >= NFUNC || lock_m) e_err = 1;
                    else if (int'(reg_wdata) != fsel_m[a]) begin
                        fsel_m[a] = int'(reg_wdata); wr_cyc[a] = cyc;
                    end
                end
`ifdef PINMUX_LOCK_EN
                else if (a == NPADS) begin
                    if (!reg_we) e_rdata = {31'b0, lock_m};
                    else if (reg_wdata[0]) lock_m = 1;
                end
`endif
                else e_err = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [32:0] ack_q[$];
    always @(negedge HCLK) begin
        logic [NPADS-1:0] ep_out, ep_oeb;
        logic [NF-1:0]    ef;
        bit g;
        if (reg_ack === 1'b1) ack_q.push_back({reg_err, reg_rdata});
        if (chk_en) begin
            for (int p = 0; p < NPADS; p++) begin
                g = (cyc - wr_cyc[p]) < GUARD;
                ep_out[p] = HRESETn && !g && fn_out[p*NFUNC + fsel_m[p]];
                ep_oeb[p] = !HRESETn || g || fn_oeb[p*NFUNC + fsel_m[p]];
                for (int f = 0; f < NFUNC; f++)
                    ef[p*NFUNC + f] = (f == fsel_m[p] && !g) ? h1[p] : IDLE;
            end
            chk("pad_out", 256'(pad_out), 256'(ep_out));
            chk("pad_oeb", 256'(pad_oeb), 256'(ep_oeb));
            chk("fn_in",   256'(fn_in),   256'(ef));
            chk("reg_ack", 256'(reg_ack), 256'(e_ack));
            if (e_ack) begin
                chk("reg_err",   256'(reg_err),   256'(e_err));
                chk("reg_rdata", 256'(reg_rdata), 256'(e_rdata));
            end
        end
    end

    // random pad/peripheral data once enabled
    always @(posedge HCLK) if (rnd_en) begin
        #1;
        pad_in = {$urandom, $urandom};
        for (int i = 0; i < NF; i += 32) begin
            fn_out[i +: 32] = $urandom;
            fn_oeb[i +: 32] = $urandom;
        end
    end

    task automatic req(input bit we, input int addr, input int data);
        reg_sel = 1; reg_we = we; reg_addr = ADDR_W'(addr); reg_wdata = 32'(data);
        @(posedge HCLK); #1;
        reg_sel = 0; reg_we = 0;
    endtask

    task automatic wait_neg();
        @(negedge HCLK); #1;
    endtask

    task automatic expect_ack(input string nm, input bit err, input bit chk_d, input logic [31:0] d);
        logic [32:0] e;
        n_cmp++;
        if (ack_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no ack seen, want err=%0d", nm, err);
        end else begin
            e = ack_q.pop_front();
            if (e[32] !== err || (chk_d && e[31:0] !== d)) begin
                n_fail++;
                $display("FAIL %s: got err=%0d data=%0d want err=%0d data=%0d", nm, e[32], e[31:0], err, d);
            end
        end
    endtask

    task automatic pulse_reset();
        HRESETn = 0; @(posedge HCLK); #1; HRESETn = 1;
    endtask

    initial begin
        // 1: reset, fn_oeb all 0, fn_out[0]=1
        fn_out[0] = 1'b1;
        @(posedge HCLK); chk_en = 1;
        repeat (2) @(posedge HCLK);
        wait_neg();
        chk("rst_oeb", 256'(pad_oeb), 256'({NPADS{1'b1}}));
        chk("rst_out", 256'(pad_out), 256'(0));
        @(posedge HCLK); #1; HRESETn = 1;
        wait_neg();
        chk("rel_out0", 256'(pad_out[0]), 256'(1));
        chk("rel_oeb0", 256'(pad_oeb[0]), 256'(0));
        rnd_en = 1;
        @(posedge HCLK); #1;
        ack_q.delete();

        // 2: write 5 = 2, guard holds 4 cycles
        req(1, 5, 2);
        wait_neg();
        expect_ack("wr5_ack", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) wait_neg();
            chk("guard_oeb5", 256'(pad_oeb[5]), 256'(1));
            chk("guard_fnin22", 256'(fn_in[22]), 256'(IDLE));
        end
        wait_neg();
        chk("post_oeb5", 256'(pad_oeb[5]), 256'(fn_oeb[22]));
        chk("post_out5", 256'(pad_out[5]), 256'(fn_out[22]));

        // 3: reload guard mid-window
        @(posedge HCLK); #1;
        req(1, 5, 1);
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;          // guard now at 2
        req(1, 5, 3);
        for (int i = 0; i < 4; i++) begin
            wait_neg();
            chk("reload_oeb5", 256'(pad_oeb[5]), 256'(1));
        end
        ack_q.delete();
        req(0, 5, 0);
        wait_neg();
        expect_ack("rd5", 0, 1, 3);

        // 4: error cases
        @(posedge HCLK); #1;
        req(1, 7, 4); req(1, 40, 1); req(0, 40, 0); req(0, 7, 0);
        wait_neg();
        expect_ack("wr7_bad", 1, 0, 0);
        expect_ack("wr40", 1, 0, 0);
        expect_ack("rd40", 1, 1, 0);
        expect_ack("rd7", 0, 1, 0);

        // 5: back-to-back
        req(1, 0, 1); req(0, 0, 0); req(0, 1, 0);
        wait_neg();
        chk("b2b_cnt", 256'(ack_q.size()), 256'(3));
        expect_ack("b2b_wr0", 0, 0, 0);
        expect_ack("b2b_rd0", 0, 1, 1);
        expect_ack("b2b_rd1", 0, 1, 0);

        // 6: lock
`ifdef PINMUX_LOCK_EN
        req(1, 38, 1); req(1, 2, 1); req(0, 2, 0); req(0, 38, 0);
        wait_neg();
        expect_ack("lock_wr", 0, 0, 0);
        expect_ack("locked_wr2", 1, 0, 0);
        expect_ack("locked_rd2", 0, 1, 0);
        expect_ack("lock_rd", 0, 1, 1);
        pulse_reset();
        req(1, 2, 1); req(0, 2, 0);
        wait_neg();
        expect_ack("unlock_wr2", 0, 0, 0);
        expect_ack("unlock_rd2", 0, 1, 1);
`else
        req(1, 38, 1);
        wait_neg();
        expect_ack("nolock_wr38", 1, 0, 0);
`endif

        // reset during guard with ack pending
        @(posedge HCLK); #1;
        req(1, 9, 1);
        pulse_reset();
        wait_neg();
        chk("rst_ack_drop", 256'(reg_ack), 256'(0));
        chk("rst_guard9", 256'(pad_oeb[9]), 256'(fn_oeb[36]));

        // random register traffic, model-checked every cycle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            if ($urandom_range(0, 2) == 0) begin
                @(posedge HCLK); #1;
            end else begin
                req(1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 5));
            end
        end
        repeat (6) @(posedge HCLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
